// File: rtl/bcd_div3_range_scanner.sv
// Scans an inclusive BCD range [lo, hi] through an external divisible-by-3 checker,
// streaming each divisible value over valid/ready and counting accepted hits.
module bcd_div3_range_scanner #(
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      lo,
    input  logic [15:0]      hi,
    output logic [15:0]      chk_d,
    input  logic             chk_q,
    output logic             hit_valid,
    output logic [15:0]      hit_value,
    input  logic             hit_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [15:0]      cur;
    logic [15:0]      hi_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;
    logic             start_ok;
    logic             accept;
    logic             advance;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [15:0] v);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // BCD digit ordering matches binary ordering, so a raw compare is enough.
    assign start_ok  = bcd_ok(lo) && bcd_ok(hi) && (lo <= hi);

    assign chk_d     = cur;
    assign hit_value = cur;
    assign hit_valid = (state == S_SCAN) && chk_q;
    assign accept    = hit_valid && hit_ready;
    assign advance   = !hit_valid || hit_ready;
    assign busy      = (state == S_SCAN);
    assign done      = (state == S_DONE);
    assign err       = err_r;
    assign count     = count_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cur     <= '0;
            hi_r    <= '0;
            count_r <= '0;
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            cur     <= lo;
                            hi_r    <= hi;
                            count_r <= '0;
                            state   <= S_SCAN;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (accept && (count_r != '1)) count_r <= count_r + CNT_W'(1);
                    if (advance) begin
                        if (cur == hi_r) state <= S_DONE;
                        else             cur   <= bcd_inc(cur);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_div3_range_scanner.sv
// Randomised self-checking bench; the checker is modelled as plain decimal arithmetic
// and every scan is predicted as an integer walk from lo to hi.
module tb_bcd_div3_range_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [15:0] chk_d;
    logic        chk_q;
    logic        hit_valid;
    logic [15:0] hit_value;
    logic        hit_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [13:0] count;

    int checks   = 0;
    int failures = 0;
    int last_cnt = 0;

    always #5 clk = ~clk;

    bcd_div3_range_scanner #(.CNT_W(14)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .chk_d     (chk_d),
        .chk_q     (chk_q),
        .hit_valid (hit_valid),
        .hit_value (hit_value),
        .hit_ready (hit_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    function automatic int to_int(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit valid_range(input logic [15:0] l, input logic [15:0] h);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (l[i*4 +: 4] > 4'd9 || h[i*4 +: 4] > 4'd9) ok = 1'b0;
        end
        return ok && (to_int(l) <= to_int(h));
    endfunction

    // External checker model: decimal value divisible by three.
    assign chk_q = (to_int(chk_d) % 3 == 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode 0: always ready; mode 1: random ready plus ignored starts; mode 2: stall 3 cycles on 0003
    task automatic run_scan(input logic [15:0] lo_b, input logic [15:0] hi_b, input int mode);
        int v, lo_i, hi_i, exp_cnt, stalls, cyc, stall_left;
        bit hexp, rdy, fin;
        lo_i = to_int(lo_b);
        hi_i = to_int(hi_b);
        @(negedge clk);
        start = 1'b1; lo = lo_b; hi = hi_b;
        @(negedge clk);
        start = 1'b0;
        v = lo_i; exp_cnt = 0; stalls = 0; cyc = 0; stall_left = 3; fin = 1'b0;
        while (!fin) begin
            check("busy", 32'(busy), 32'd1);
            check("chk_d", 32'(chk_d), 32'(to_bcd(v)));
            hexp = (v % 3 == 0);
            check("hit_valid", 32'(hit_valid), 32'(hexp));
            if (hexp) check("hit_value", 32'(hit_value), 32'(to_bcd(v)));
            check("err_scan", 32'(err), 32'd0);
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2: begin
                    rdy = !(v == 3 && stall_left > 0);
                    if (!rdy) stall_left--;
                end
                default: rdy = 1'b1;
            endcase
            hit_ready = rdy;
            if (mode == 1) begin
                start = ($urandom_range(0, 7) == 0);
                lo = 16'($urandom);
                hi = 16'($urandom);
            end
            if (hexp && rdy) exp_cnt++;
            if (hexp && !rdy) stalls++;
            if (!hexp || rdy) begin
                if (v == hi_i) fin = 1'b1;
                else v++;
            end
            cyc++;
            @(negedge clk);
            if (cyc > 12000) begin
                check("timeout", 32'd1, 32'd0);
                fin = 1'b1;
            end
        end
        start = 1'b0;
        hit_ready = 1'b1;
        check("done", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("err_done", 32'(err), 32'd0);
        check("count", 32'(count), 32'(exp_cnt));
        check("scan_cycles", 32'(cyc), 32'(hi_i - lo_i + 1 + stalls));
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
        check("count_hold", 32'(count), 32'(exp_cnt));
        last_cnt = exp_cnt;
    endtask

    task automatic try_bad(input logic [15:0] lo_b, input logic [15:0] hi_b);
        @(negedge clk);
        start = 1'b1; lo = lo_b; hi = hi_b;
        @(negedge clk);
        start = 1'b0;
        check("err", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_done", 32'(done), 32'd0);
        @(negedge clk);
        check("err_pulse", 32'(err), 32'd0);
        check("err_busy2", 32'(busy), 32'd0);
        check("err_count", 32'(count), 32'(last_cnt));
    endtask

    task automatic reset_mid_scan();
        int n;
        @(negedge clk);
        start = 1'b1; lo = 16'h0000; hi = 16'h0099; hit_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (chk_d !== 16'h0050 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_0050", 32'(chk_d), 32'h0050);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_chk_d", 32'(chk_d), 32'd0);
        check("rst_hit_valid", 32'(hit_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        check("rst_no_done", 32'(done), 32'd0);
        check("rst_idle", 32'(busy), 32'd0);
        last_cnt = 0;
    endtask

    initial begin
        logic [15:0] rl, rh;
        int l_i, h_i;
        rst = 1'b1; start = 1'b0; lo = '0; hi = '0; hit_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_chk_d", 32'(chk_d), 32'd0);
        check("reset_hit_valid", 32'(hit_valid), 32'd0);
        check("reset_hit_value", 32'(hit_value), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_count", 32'(count), 32'd0);

        run_scan(16'h0000, 16'h0009, 0);
        run_scan(16'h0098, 16'h0102, 0);
        run_scan(16'h0000, 16'h0009, 2);
        try_bad(16'h0123, 16'h0100);
        try_bad(16'h00A0, 16'h0100);
        try_bad(16'h0100, 16'h01F0);
        run_scan(16'h0000, 16'h0030, 1);
        run_scan(16'h9999, 16'h9999, 0);
        run_scan(16'h0005, 16'h0005, 0);

        for (int k = 0; k < 6; k++) begin
            l_i = $urandom_range(0, 9999);
            h_i = l_i + $urandom_range(0, 40);
            if (h_i > 9999) h_i = 9999;
            run_scan(to_bcd(l_i), to_bcd(h_i), 1);
        end
        for (int k = 0; k < 6; k++) begin
            rl = 16'($urandom);
            rh = 16'($urandom);
            if (!valid_range(rl, rh)) try_bad(rl, rh);
        end

        run_scan(16'h0000, 16'h9999, 0);
        reset_mid_scan();
        run_scan(16'h0010, 16'h0020, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
